// File: rtl/ram8_reader_pkg.sv
// Shared RAM8 geometry and reader FSM encoding, used by RAM8, its loaders and the reader.
package ram8_reader_pkg;

  localparam int unsigned Ram8Width = 16;
  localparam int unsigned Ram8AddrW = 3;
  localparam int unsigned Ram8Depth = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2,
    StDone  = 2'd3
  } reader_state_e;

endpackage

// File: rtl/ram8_addr_counter.sv
// Sweep pointer with modulo wrap plus the down-counter of words still to deliver.
module ram8_addr_counter
  import ram8_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = Ram8AddrW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  input  logic              advance,
  output logic [ADDR_W-1:0] ptr,
  output logic              last
);

  localparam logic [ADDR_W:0] MaxCount = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] OneCount = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [ADDR_W:0]   count_clamped;

  assign count_clamped = (count > MaxCount) ? MaxCount : count;
  assign last          = (rem_q == OneCount);
  assign ptr           = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    rem_d = rem_q;
    if (load) begin
      ptr_d = base;
      rem_d = count_clamped;
    end else if (advance) begin
      rem_d = rem_q - OneCount;
      // The pointer stays on the final word so ram_address is stable into DONE.
      if (!last) begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      rem_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      rem_q <= rem_d;
    end
  end

endmodule

// File: rtl/ram8_reader.sv
// Read-only sweep engine for RAM8: fetches a (possibly wrapping) address range and
// presents each word on a valid/ready stream, pulsing done when the sweep ends.
module ram8_reader
  import ram8_reader_pkg::*;
#(
  parameter int unsigned WIDTH  = Ram8Width,
  parameter int unsigned ADDR_W = Ram8AddrW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_load,
  output logic [WIDTH-1:0]  ram_in,
  input  logic [WIDTH-1:0]  ram_out,
  output logic [WIDTH-1:0]  data,
  output logic [ADDR_W-1:0] data_addr,
  output logic              valid,
  input  logic              ready,
  output logic              busy,
  output logic              done
);

  reader_state_e state_q, state_d;

  logic [WIDTH-1:0]  data_q, data_d;
  logic [ADDR_W-1:0] data_addr_q, data_addr_d;
  logic              valid_q, valid_d;

  logic              cnt_load, cnt_advance, cnt_last;
  logic [ADDR_W-1:0] ptr;

  ram8_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_addr_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .base    (base),
    .count   (count),
    .advance (cnt_advance),
    .ptr     (ptr),
    .last    (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (count == '0) ? StDone : StFetch;
        end
      end
      StFetch: state_d = StHold;
      StHold: begin
        if (ready) begin
          state_d = cnt_last ? StDone : StFetch;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Captured word is only replaced in FETCH, so RAM8 changes during HOLD are invisible.
  always_comb begin
    data_d      = data_q;
    data_addr_d = data_addr_q;
    valid_d     = valid_q;
    if (state_q == StFetch) begin
      data_d      = ram_out;
      data_addr_d = ptr;
      valid_d     = 1'b1;
    end else if (state_q == StHold && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q      <= '0;
      data_addr_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      data_q      <= data_d;
      data_addr_q <= data_addr_d;
      valid_q     <= valid_d;
    end
  end

  always_comb begin
    cnt_load    = (state_q == StIdle) && start && (count != '0);
    cnt_advance = (state_q == StHold) && ready;
    busy        = (state_q != StIdle);
    done        = (state_q == StDone);
    ram_address = ptr;
    ram_load    = 1'b0;
    ram_in      = '0;
    data        = data_q;
    data_addr   = data_addr_q;
    valid       = valid_q;
  end

endmodule

// File: tb/tb_ram8_reader.sv
// Scoreboard bench for ram8_reader against a behavioural RAM8 preloaded with 16'h1111*k.
module tb_ram8_reader;

  localparam int unsigned W  = 16;
  localparam int unsigned AW = 3;

  typedef struct {
    logic [W-1:0]  d;
    logic [AW-1:0] a;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   count;
  logic [AW-1:0] ram_address;
  logic          ram_load;
  logic [W-1:0]  ram_in;
  logic [W-1:0]  ram_out;
  logic [W-1:0]  data;
  logic [AW-1:0] data_addr;
  logic          valid;
  logic          ready;
  logic          busy;
  logic          done;

  logic [W-1:0] mem [8];
  bit           mem_init_done;
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  bit           mon_en = 1'b0;
  exp_t         sb_q[$];
  int           done_q[$];

  ram8_reader #(
    .WIDTH  (W),
    .ADDR_W (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base        (base),
    .count       (count),
    .ram_address (ram_address),
    .ram_load    (ram_load),
    .ram_in      (ram_in),
    .ram_out     (ram_out),
    .data        (data),
    .data_addr   (data_addr),
    .valid       (valid),
    .ready       (ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM8: preload once, then honour any write the reader might issue.
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int k = 0; k < 8; k++) mem[k] <= 16'(k * 32'h1111);
      mem_init_done <= 1'b1;
    end else if (ram_load) begin
      mem[ram_address] <= ram_in;
    end
  end

  assign ram_out = mem[ram_address];

  function automatic logic [W-1:0] word_of(input int a);
    return 16'(a * 32'h1111);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every presented word and done pulse against the queues.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        check("ram_load_low", {31'b0, ram_load}, 32'd0);
        check("valid_done_exclusive", {31'b0, valid & done}, 32'd0);
        if (valid === 1'b1) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_word: got addr %0h data %0h expected none", data_addr, data);
          end else begin
            check("word_data", {16'b0, data}, {16'b0, sb_q[0].d});
            check("word_addr", {29'b0, data_addr}, {29'b0, sb_q[0].a});
            if (ready === 1'b1) void'(sb_q.pop_front());
          end
        end
        if (done === 1'b1) begin
          if (done_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
          end else begin
            check("done_cycle", cyc, done_q.pop_front());
          end
        end
      end
    end
  end

  task automatic start_sweep(input logic [AW-1:0] b, input logic [AW:0] c, input int stall);
    int n;
    n = (c > 4'd8) ? 8 : int'(c);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back('{d: word_of((int'(b) + i) % 8), a: 3'((int'(b) + i) % 8)});
    end
    @(negedge clk);
    start = 1'b1;
    base  = b;
    count = c;
    @(posedge clk);
    #1;
    start = 1'b0;
    base  = ~b;
    count = 4'd1;
    done_q.push_back(cyc + 2 * n + stall);
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (busy === 1'b0) break;
    end
    check(name, {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (valid === 1'b1) break;
    end
    check(name, {31'b0, valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    base  = '0;
    count = '0;
    ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_data", {16'b0, data}, 32'd0);
    check("rst_data_addr", {29'b0, data_addr}, 32'd0);
    check("rst_ram_address", {29'b0, ram_address}, 32'd0);
    mon_en = 1'b1;

    // Full sweep: words 0..7, done 16 edges after the start edge.
    start_sweep(3'd0, 4'd8, 0);
    wait_idle("full_idle");

    // Wrapping sweep 6,7,0,1.
    start_sweep(3'd6, 4'd4, 0);
    wait_idle("wrap_idle");

    // Backpressure: hold the first word for five valid cycles.
    ready = 1'b0;
    start_sweep(3'd2, 4'd2, 5);
    wait_valid("bp_first_valid");
    repeat (5) @(negedge clk);
    ready = 1'b1;
    wait_idle("bp_idle");

    // Empty sweep: done right after the start edge, no words.
    start_sweep(3'd4, 4'd0, 0);
    wait_idle("empty_idle");

    // Oversized count clamps to eight words starting at 4.
    start_sweep(3'd4, 4'd12, 0);
    wait_idle("clamp_idle");

    // Start while busy must be ignored.
    start_sweep(3'd1, 4'd3, 0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    base  = 3'd5;
    count = 4'd2;
    @(negedge clk);
    start = 1'b0;
    wait_idle("restart_idle");

    // Reset while a word is held: the pending word and done are dropped.
    ready = 1'b0;
    start_sweep(3'd0, 4'd4, 0);
    wait_valid("midrst_valid");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb_q.delete();
    done_q.delete();
    @(negedge clk);
    reset = 1'b0;
    ready = 1'b1;
    #1;
    check("midrst_valid_low", {31'b0, valid}, 32'd0);
    check("midrst_busy_low", {31'b0, busy}, 32'd0);
    check("midrst_data_zero", {16'b0, data}, 32'd0);
    start_sweep(3'd3, 4'd1, 0);
    wait_idle("post_rst_idle");

    repeat (2) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    check("done_q_empty", done_q.size(), 32'd0);
    for (int k = 0; k < 8; k++) begin
      check("mem_intact", {16'b0, mem[k]}, {16'b0, word_of(k)});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
